// File: rtl/muldiv_hilo_if.sv
// Handshake/data bundle between EX-stage control and the HI/LO mul/div unit.
// The master issues Start/Op/A/B; the slave returns Busy/Done and HI/LO.
interface muldiv_hilo_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [2:0]       Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output Start, Op, A, B,
    input  Busy, Done, HI, LO
  );

  modport slave (
    input  Start, Op, A, B,
    output Busy, Done, HI, LO
  );
endinterface

// File: rtl/muldiv_hilo_unit.sv
// Iterative shift-add multiply / restoring divide unit owning HI/LO.
// One bit per cycle on magnitudes; signs are fixed up in a final cycle.
module muldiv_hilo_unit #(
  parameter int WIDTH = 32
) (
  input  logic        Clk,
  input  logic        Rst,
  muldiv_hilo_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    FIX
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] wrk_q, wrk_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             neg_q, neg_d;
  logic             dneg_q, dneg_d;
  logic             isdiv_q, isdiv_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic             sgn_op;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   sh;
  logic [WIDTH:0]   diff;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  assign sgn_op = (bus.Op == OP_MULT) || (bus.Op == OP_DIV);
  assign a_neg  = sgn_op && bus.A[WIDTH-1];
  assign b_neg  = sgn_op && bus.B[WIDTH-1];
  assign a_mag  = a_neg ? -bus.A : bus.A;
  assign b_mag  = b_neg ? -bus.B : bus.B;

  // wrk_q is the multiplier (shifted out LSB first) or the dividend/quotient
  assign sum  = {1'b0, acc_q} +
                (wrk_q[0] ? {1'b0, opnd_q} : '0);
  assign sh   = {acc_q, wrk_q[WIDTH-1]};
  assign diff = sh - {1'b0, opnd_q};

  assign prod     = {acc_q, wrk_q};
  assign prod_fix = neg_q ? -prod : prod;
  // zero divisor yields an all-ones quotient and the dividend as remainder
  assign quo_fix  = dz_q ? '1 : (neg_q ? -wrk_q : wrk_q);
  assign rem_fix  = dneg_q ? -acc_q : acc_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    wrk_d   = wrk_q;
    opnd_d  = opnd_q;
    neg_d   = neg_q;
    dneg_d  = dneg_q;
    isdiv_d = isdiv_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          case (bus.Op)
            OP_MTHI: hi_d = bus.A;
            OP_MTLO: lo_d = bus.A;
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              acc_d   = '0;
              wrk_d   = a_mag;
              opnd_d  = b_mag;
              neg_d   = a_neg ^ b_neg;
              dneg_d  = a_neg;
              isdiv_d = (bus.Op == OP_DIV) ||
                        (bus.Op == OP_DIVU);
              dz_d    = (bus.B == '0);
              cnt_d   = CW'(WIDTH);
              state_d = isdiv_d ? DIV : MUL;
            end
            default: ;
          endcase
        end
      end
      MUL: begin
        acc_d = sum[WIDTH:1];
        wrk_d = {sum[0], wrk_q[WIDTH-1:1]};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      DIV: begin
        if (!diff[WIDTH]) begin
          acc_d = diff[WIDTH-1:0];
          wrk_d = {wrk_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = sh[WIDTH-1:0];
          wrk_d = {wrk_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        if (isdiv_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      wrk_q   <= '0;
      opnd_q  <= '0;
      neg_q   <= 1'b0;
      dneg_q  <= 1'b0;
      isdiv_q <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      wrk_q   <= wrk_d;
      opnd_q  <= opnd_d;
      neg_q   <= neg_d;
      dneg_q  <= dneg_d;
      isdiv_q <= isdiv_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign bus.Busy = (state_q != IDLE);
  assign bus.Done = done_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;
endmodule

// File: doc/muldiv_hilo_unit.md
Name: muldiv_hilo_unit

Overview:
- Iterative multiply/divide unit for the pipelined datapath's EX stage.
- Takes two register operands and produces one 2*WIDTH-bit result, split across the HI and LO architectural registers.
- Owns HI/LO storage and its Busy flag. The hazard unit uses Busy to stall MFHI/MFLO and any new mult/div op. The EX-stage 2:1 mux selects HI or LO for MFHI/MFLO.

Parameters:
- WIDTH, 32, operand width and HI/LO register width.

Ports:
- Clk  input  1  rising-edge clock.
- Rst  input  1  synchronous, active-high reset.
- Start  input  1  request; sampled only when Busy=0.
- Op  input  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 none.
- A  input  WIDTH  rs operand: multiplicand or dividend; data for MTHI/MTLO.
- B  input  WIDTH  rt operand: multiplier or divisor.
- Busy  output  1  operation in progress.
- Done  output  1  one-cycle pulse; HI/LO hold the new result.
- HI  output  WIDTH  HI register: product upper half, or remainder.
- LO  output  WIDTH  LO register: product lower half, or quotient.

Behaviour:
- Reset: all state returns to defaults on the Rst edge.
  - HI=0, LO=0, Busy=0, Done=0, state=IDLE, iteration counter=0.
  - Rst has priority over every other input.
  - Rst mid-operation aborts the operation; HI/LO are cleared and no Done is produced.
- FSM states: IDLE, MUL, DIV, FIX.
- IDLE, Start=1, Op=MTHI/MTLO:
  - On the next edge HI (resp. LO) <= A.
  - Busy stays 0; no Done.
- IDLE, Start=1, Op=MULT/MULTU/DIV/DIVU:
  - On that edge, latch the operands and the sign info.
  - Signed ops: convert operands to magnitudes; record result sign and dividend sign.
  - Counter <= WIDTH; Busy <= 1; go to MUL or DIV.
- IDLE, Start=1, Op=none: ignored.
- MUL: shift-add, one multiplier bit per edge. Counter decrements; at 0, go to FIX.
- DIV: restoring divide, one quotient bit per edge. Counter decrements; at 0, go to FIX.
- FIX: apply sign correction and write HI/LO, then Busy <= 0, Done <= 1, state=IDLE.
- Latency: accept edge E0, iterations on E1..E_WIDTH, write on E_WIDTH+1.
  - Busy is high for exactly WIDTH+1 cycles.
  - Done and the new HI/LO become visible together, WIDTH+1 cycles after acceptance.
- Done is high for one cycle only. A new Start in that same cycle is accepted.
- HI/LO hold their old values for the whole duration of an operation.
- Start while Busy=1 is ignored (any Op, including MTHI/MTLO). The hazard unit must stall.
- Multiply: {HI,LO} = full 2*WIDTH product.
  - MULT: two's-complement signed.
  - MULTU: unsigned.
- Divide: LO = quotient, HI = remainder.
  - Signed quotient truncates toward zero; remainder takes the sign of the dividend.
- Divide by zero (B=0), DIV or DIVU: LO = all ones, HI = A. Same latency as a normal divide.
- Signed overflow, DIV with A = most negative value and B = -1: LO = 0x80000000, HI = 0.
- A and B may change after acceptance without affecting the result.

Test Plan:
- Reset then MTHI A=0x12345678; MTLO A=0xCAFEBABE -> HI=0x12345678, LO=0xCAFEBABE one cycle after each; Busy/Done never asserted.
- MULT A=0xFFFFFFFD(-3), B=7 -> Busy high 33 cycles, then Done pulse; HI=0xFFFFFFFF, LO=0xFFFFFFEB; HI/LO unchanged while Busy.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV A=0xFFFFFFF9(-7), B=2 -> LO=0xFFFFFFFD(-3), HI=0xFFFFFFFF(-1). DIVU A=100, B=7 -> LO=14, HI=2.
- DIVU A=0x55, B=0 -> LO=0xFFFFFFFF, HI=0x55. DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- Start MULT, then pulse Start with MTLO at cycle 5 and Rst at cycle 10 -> MTLO ignored; after Rst, HI=LO=0, Busy=0, no Done. Then Start DIVU 9/3 in the same cycle as the previous Done -> accepted, LO=3, HI=0.
